// File: rtl/execute.sv
// ---------------------------------------------------------------------------
// execute -- single-cycle execute stage with its own register file.
//
// Ports
//   clk                 rising-edge clock for all state
//   rst                 asynchronous, active-high reset
//   Aval                A operand as read by Decode (used when Ra = 14)
//   Bval                B operand as read by Decode, or the sign-extended
//                       immediate when Imb = 1 (used when Imb = 1 or Rb >= 14)
//   instructionExecute  instruction word; the all-zero word is a bubble
//   r                   architectural registers r0..r13
//   overflow            overflow / high-word register (architectural r15)
//   flag                condition flag written by compare-form instructions
//   jump                one-cycle redirect pulse
//   jumpTarget          redirect PC, meaningful only while jump = 1
//
// Instruction fields: Imb[31] Ra[30:27] Rb[26:23] Imm[26:13] Opc[12:8]
//                     Rc[7:4] Cond[3:1] Cmp[0]
// ---------------------------------------------------------------------------
module execute (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Aval,
    input  logic [31:0] Bval,
    input  logic [31:0] instructionExecute,
    output logic [31:0] r [13:0],
    output logic [31:0] overflow,
    output logic        flag,
    output logic        jump,
    output logic [31:0] jumpTarget
);

    localparam logic [4:0] OP_MOV  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_ADD  = 5'd5;
    localparam logic [4:0] OP_ADDC = 5'd6;
    localparam logic [4:0] OP_SUB  = 5'd7;
    localparam logic [4:0] OP_MUL  = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_SHR  = 5'd10;
    localparam logic [4:0] OP_SRA  = 5'd11;
    localparam logic [4:0] OP_EQ   = 5'd12;
    localparam logic [4:0] OP_LT   = 5'd13;

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic       imb;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [4:0] opc;
    logic [3:0] rc;
    logic [2:0] cond;
    logic       cmp;

    assign imb  = instructionExecute[31];
    assign ra   = instructionExecute[30:27];
    assign rb   = instructionExecute[26:23];
    assign opc  = instructionExecute[12:8];
    assign rc   = instructionExecute[7:4];
    assign cond = instructionExecute[3:1];
    assign cmp  = instructionExecute[0];

    // The low immediate bits only matter to Decode, which already folded
    // them into Bval.
    logic unused_imm_low;
    assign unused_imm_low = ^instructionExecute[22:13];

    // ------------------------------------------------------------------
    // Operand selection. Reading r0..r13 from the local file (not from the
    // Decode-latched value) picks up a write made on the previous edge.
    // ------------------------------------------------------------------
    logic [31:0] op_a;
    logic [31:0] op_b;

    always_comb begin
        if (ra == 4'd14) begin
            op_a = Aval;
        end else if (ra == 4'd15) begin
            op_a = overflow;
        end else begin
            op_a = r[ra];
        end
    end

    always_comb begin
        if (imb || (rb >= 4'd14)) begin
            op_b = Bval;
        end else begin
            op_b = r[rb];
        end
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic        carry_in;
    logic [32:0] sum;
    logic [63:0] product;

    assign carry_in = (opc == OP_ADDC) ? overflow[0] : 1'b0;
    assign sum      = {1'b0, op_a} + {1'b0, op_b} + {32'd0, carry_in};
    assign product  = {32'd0, op_a} * {32'd0, op_b};

    logic [31:0] result;
    logic        known_op;
    logic        ovf_implicit_en;
    logic [31:0] ovf_implicit;

    always_comb begin
        result          = '0;
        known_op        = 1'b1;
        ovf_implicit_en = 1'b0;
        ovf_implicit    = '0;
        case (opc)
            OP_MOV: result = op_b;
            OP_AND: result = op_a & op_b;
            OP_OR:  result = op_a | op_b;
            OP_XOR: result = op_a ^ op_b;
            OP_ADD, OP_ADDC: begin
                result          = sum[31:0];
                ovf_implicit_en = 1'b1;
                ovf_implicit    = {31'd0, sum[32]};
            end
            OP_SUB: begin
                result          = op_a - op_b;
                ovf_implicit_en = 1'b1;
                ovf_implicit    = {31'd0, (op_a < op_b)};
            end
            OP_MUL: begin
                result          = product[31:0];
                ovf_implicit_en = 1'b1;
                ovf_implicit    = product[63:32];
            end
            OP_SHL: result = op_a << op_b[4:0];
            OP_SHR: result = op_a >> op_b[4:0];
            OP_SRA: result = $unsigned($signed(op_a) >>> op_b[4:0]);
            OP_EQ:  result = {31'd0, (op_a == op_b)};
            OP_LT:  result = {31'd0, ($signed(op_a) < $signed(op_b))};
            default: known_op = 1'b0;   // opcode 0 and 14..31 do nothing
        endcase
    end

    // ------------------------------------------------------------------
    // Issue control
    // ------------------------------------------------------------------
    logic squash_reg;
    logic squash_next;
    logic bubble;
    logic cond_pass;
    logic active;
    logic reg_write;
    logic ovf_direct;
    logic ovf_we;
    logic [31:0] ovf_next;
    logic flag_we;
    logic jump_next;

    always_comb begin
        case (cond)
            3'd0:    cond_pass = 1'b1;
            3'd1:    cond_pass = flag;
            3'd2:    cond_pass = ~flag;
            default: cond_pass = 1'b0;
        endcase
    end

    assign bubble = (instructionExecute == 32'd0);

    // A pending squash kills the next real instruction, whatever it is;
    // bubbles pass through and leave the squash armed.
    assign active = ~bubble & ~squash_reg & cond_pass & known_op;

    assign reg_write  = active & ~cmp & (rc < 4'd14);
    assign ovf_direct = ~cmp & (rc == 4'd15);
    assign ovf_we     = active & (ovf_direct | ovf_implicit_en);
    // An explicit Rc = 15 write overrides the arithmetic side effect.
    assign ovf_next   = ovf_direct ? result : ovf_implicit;
    assign flag_we    = active & cmp;
    assign jump_next  = active & ~cmp & (rc == 4'd14);

    assign squash_next = jump_next | (squash_reg & bubble);

    logic [13:0] wr_en;

    generate
        for (genvar gi = 0; gi < 14; gi++) begin : g_wr_en
            assign wr_en[gi] = reg_write & (rc == 4'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 14; i++) begin
                r[i] <= '0;
            end
            overflow   <= '0;
            flag       <= 1'b0;
            jump       <= 1'b0;
            jumpTarget <= '0;
            squash_reg <= 1'b0;
        end else begin
            for (int i = 0; i < 14; i++) begin
                if (wr_en[i]) begin
                    r[i] <= result;
                end
            end
            if (ovf_we) begin
                overflow <= ovf_next;
            end
            if (flag_we) begin
                flag <= (result != 32'd0);
            end
            jump <= jump_next;
            if (jump_next) begin
                jumpTarget <= result;
            end
            squash_reg <= squash_next;
        end
    end

endmodule

// File: tb/tb_execute.sv
// ---------------------------------------------------------------------------
// tb_execute -- self-checking bench for execute.
// A behavioural model tracks the architectural state; a compare process
// checks every DUT output against it on each falling edge. Directed
// sequences with literal expectations pin the model, followed by a long
// randomized run with occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Aval;
    logic [31:0] Bval;
    logic [31:0] instructionExecute;
    logic [31:0] r [13:0];
    logic [31:0] overflow;
    logic        flag;
    logic        jump;
    logic [31:0] jumpTarget;

    execute dut (
        .clk                (clk),
        .rst                (rst),
        .Aval               (Aval),
        .Bval               (Bval),
        .instructionExecute (instructionExecute),
        .r                  (r),
        .overflow           (overflow),
        .flag               (flag),
        .jump               (jump),
        .jumpTarget         (jumpTarget)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state
    logic [31:0] m_r [14];
    logic [31:0] m_ovf;
    logic        m_flag;
    logic        m_jump;
    logic [31:0] m_jt;
    logic        m_squash;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 14; i++) m_r[i] = '0;
        m_ovf    = '0;
        m_flag   = 1'b0;
        m_jump   = 1'b0;
        m_jt     = '0;
        m_squash = 1'b0;
    endtask

    // One architectural step of the machine for a given input triple.
    task automatic model_step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ins);
        logic [3:0]  ra, rb, rc;
        logic [4:0]  opc;
        logic [2:0]  cond;
        logic        imb, cbit, run, ok, has_ovf;
        logic [31:0] A, B, res, novf;
        logic [63:0] wide;
        m_jump = 1'b0;
        if (ins == 32'd0) return;
        if (m_squash) begin
            m_squash = 1'b0;
            return;
        end
        imb  = ins[31];
        ra   = ins[30:27];
        rb   = ins[26:23];
        opc  = ins[12:8];
        rc   = ins[7:4];
        cond = ins[3:1];
        cbit = ins[0];
        A = (ra == 4'd14) ? a : ((ra == 4'd15) ? m_ovf : m_r[ra]);
        B = (imb || rb >= 4'd14) ? b : m_r[rb];
        run = (cond == 3'd0) || (cond == 3'd1 && m_flag) || (cond == 3'd2 && !m_flag);
        if (!run) return;
        has_ovf = 1'b0;
        novf    = '0;
        ok      = 1'b1;
        res     = '0;
        wide    = '0;
        case (opc)
            5'd1:  res = B;
            5'd2:  res = A & B;
            5'd3:  res = A | B;
            5'd4:  res = A ^ B;
            5'd5, 5'd6: begin
                wide = {32'd0, A} + {32'd0, B};
                if (opc == 5'd6) wide = wide + {63'd0, m_ovf[0]};
                res = wide[31:0];
                novf = wide[63:32];
                has_ovf = 1'b1;
            end
            5'd7: begin
                res = A - B;
                novf = (A < B) ? 32'd1 : 32'd0;
                has_ovf = 1'b1;
            end
            5'd8: begin
                wide = {32'd0, A} * {32'd0, B};
                res = wide[31:0];
                novf = wide[63:32];
                has_ovf = 1'b1;
            end
            5'd9:  res = A << B[4:0];
            5'd10: res = A >> B[4:0];
            5'd11: res = $unsigned($signed(A) >>> B[4:0]);
            5'd12: res = (A == B) ? 32'd1 : 32'd0;
            5'd13: res = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
            default: ok = 1'b0;
        endcase
        if (!ok) return;
        if (has_ovf) m_ovf = novf;
        if (cbit) begin
            m_flag = (res != 32'd0);
        end else if (rc < 4'd14) begin
            m_r[rc] = res;
        end else if (rc == 4'd14) begin
            m_jump   = 1'b1;
            m_jt     = res;
            m_squash = 1'b1;
        end else begin
            m_ovf = res;
        end
    endtask

    // Compare process: every falling edge the outputs are settled.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 14; i++) chk($sformatf("r[%0d]", i), r[i], m_r[i]);
            chk("overflow", overflow, m_ovf);
            chk("flag", {31'd0, flag}, {31'd0, m_flag});
            chk("jump", {31'd0, jump}, {31'd0, m_jump});
            if (m_jump) chk("jumpTarget", jumpTarget, m_jt);
        end
    end

    function automatic logic [31:0] ins_w(input logic imb, input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [13:0] imm, input logic [4:0] opc, input logic [3:0] rc,
                                          input logic [2:0] cond, input logic cbit);
        logic [31:0] w;
        w = '0;
        w[31] = imb;
        w[30:27] = ra;
        if (imb) w[26:13] = imm;
        else w[26:23] = rb;
        w[12:8] = opc;
        w[7:4] = rc;
        w[3:1] = cond;
        w[0] = cbit;
        return w;
    endfunction

    function automatic logic [31:0] rr(input logic [4:0] opc, input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [3:0] rc, input logic [2:0] cond, input logic cbit);
        return ins_w(1'b0, ra, rb, 14'd0, opc, rc, cond, cbit);
    endfunction

    function automatic logic [31:0] sext(input logic [13:0] imm);
        return {{18{imm[13]}}, imm};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    // One transaction: drive inputs, advance one edge, step the model.
    task automatic cyc(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ins);
        Aval = a;
        Bval = b;
        instructionExecute = ins;
        @(posedge clk);
        if (!rst) model_step(a, b, ins);
        n_txn++;
        $display("txn %0d ins=%08h A=%08h B=%08h", n_txn, ins, a, b);
        #1;
    endtask

    // OR of Aval with a zero B: writes an arbitrary 32-bit value into r[rc].
    task automatic load(input logic [3:0] rc, input logic [31:0] val);
        cyc(val, 32'd0, rr(5'd3, 4'd14, 4'd14, rc, 3'd0, 1'b0));
    endtask

    task automatic async_reset();
        #1 rst = 1'b1;
        m_reset();
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic        imb, cbit;
        logic [3:0]  ra, rb, rc;
        logic [4:0]  opc;
        logic [2:0]  cond;
        logic [13:0] imm;
        logic [31:0] a, b, ins;
        int          sel;

        rst = 1'b1;
        Aval = '0;
        Bval = '0;
        instructionExecute = '0;
        m_reset();
        cmp_en = 1'b1;

        // An instruction held during reset must do nothing.
        Aval = 32'd5;
        instructionExecute = rr(5'd3, 4'd14, 4'd14, 4'd1, 3'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset r1", r[1], 32'd0);
        chk("reset overflow", overflow, 32'd0);
        chk("reset flag", {31'd0, flag}, 32'd0);
        chk("reset jump", {31'd0, jump}, 32'd0);
        chk("reset jumpTarget", jumpTarget, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        // First edge after release executes.
        load(4'd1, 32'd5);
        chk("first exec r1", r[1], 32'd5);

        // ADD with carry out, then ADDC reading overflow through Ra = 15.
        load(4'd1, 32'hFFFF_FFFF);
        load(4'd2, 32'd1);
        cyc(32'd0, 32'd0, rr(5'd5, 4'd1, 4'd2, 4'd3, 3'd0, 1'b0));
        chk("add r3", r[3], 32'd0);
        chk("add overflow", overflow, 32'd1);
        cyc(32'd0, 32'd0, ins_w(1'b1, 4'd15, 4'd0, 14'd0, 5'd6, 4'd4, 3'd0, 1'b0));
        chk("addc r4", r[4], 32'd2);
        chk("addc overflow", overflow, 32'd0);

        // MUL high word into overflow, then back-to-back bypass read.
        load(4'd5, 32'h0000_AAAA);
        load(4'd6, 32'h0000_1234);
        load(4'd1, 32'h0001_0000);
        load(4'd2, 32'h0001_0000);
        cyc(32'd0, 32'd0, rr(5'd8, 4'd1, 4'd2, 4'd5, 3'd0, 1'b0));
        chk("mul r5", r[5], 32'd0);
        chk("mul overflow", overflow, 32'd1);
        cyc(32'd0, 32'd0, rr(5'd1, 4'd0, 4'd5, 4'd6, 3'd0, 1'b0));
        chk("bypass r6", r[6], 32'd0);

        // Signed compare sets flag; conditional execution.
        load(4'd1, 32'hFFFF_FFFF);
        load(4'd2, 32'd1);
        load(4'd7, 32'h77);
        cyc(32'd0, 32'd0, rr(5'd13, 4'd1, 4'd2, 4'd7, 3'd0, 1'b1));
        chk("lt flag", {31'd0, flag}, 32'd1);
        chk("lt r7 kept", r[7], 32'h77);
        cyc(32'd0, 32'd0, rr(5'd5, 4'd2, 4'd2, 4'd8, 3'd2, 1'b0));
        chk("cond2 r8", r[8], 32'd0);
        chk("cond2 overflow", overflow, 32'd1);
        cyc(32'd0, 32'd0, rr(5'd5, 4'd2, 4'd2, 4'd8, 3'd1, 1'b0));
        chk("cond1 r8", r[8], 32'd2);
        chk("cond1 overflow", overflow, 32'd0);

        // Jump, bubble, squashed ADD, then a normal ADD.
        cyc(32'd0, sext(14'h40), ins_w(1'b1, 4'd0, 4'd0, 14'h40, 5'd1, 4'd14, 3'd0, 1'b0));
        chk("jump pulse", {31'd0, jump}, 32'd1);
        chk("jump target", jumpTarget, 32'h40);
        cyc(32'd0, 32'd0, 32'd0);
        chk("jump one cycle", {31'd0, jump}, 32'd0);
        cyc(32'd0, 32'd0, rr(5'd5, 4'd2, 4'd2, 4'd7, 3'd0, 1'b0));
        chk("squashed r7", r[7], 32'h77);
        cyc(32'd0, 32'd0, rr(5'd5, 4'd2, 4'd2, 4'd7, 3'd0, 1'b0));
        chk("after squash r7", r[7], 32'd2);

        // Undefined opcode and never-condition do nothing.
        cyc(32'd0, 32'd0, rr(5'd20, 4'd2, 4'd2, 4'd9, 3'd0, 1'b0));
        cyc(32'd0, 32'd0, rr(5'd20, 4'd1, 4'd2, 4'd9, 3'd0, 1'b1));
        cyc(32'd0, 32'd0, rr(5'd5, 4'd2, 4'd2, 4'd9, 3'd5, 1'b0));
        cyc(32'd0, 32'd0, rr(5'd20, 4'd2, 4'd2, 4'd14, 3'd0, 1'b0));
        chk("nop r9", r[9], 32'd0);
        chk("nop flag", {31'd0, flag}, 32'd1);
        chk("nop overflow", overflow, 32'd0);
        chk("nop jump", {31'd0, jump}, 32'd0);

        // A squashed jump neither jumps nor re-arms the squash.
        cyc(32'd0, sext(14'h40), ins_w(1'b1, 4'd0, 4'd0, 14'h40, 5'd1, 4'd14, 3'd0, 1'b0));
        cyc(32'd0, sext(14'h80), ins_w(1'b1, 4'd0, 4'd0, 14'h80, 5'd1, 4'd14, 3'd0, 1'b0));
        chk("squashed jump", {31'd0, jump}, 32'd0);
        cyc(32'd0, 32'd0, rr(5'd5, 4'd2, 4'd2, 4'd9, 3'd0, 1'b0));
        chk("no rearm r9", r[9], 32'd2);

        // Asynchronous reset in the middle of a jump cycle.
        cyc(32'd0, sext(14'h40), ins_w(1'b1, 4'd0, 4'd0, 14'h40, 5'd1, 4'd14, 3'd0, 1'b0));
        #1 rst = 1'b1;
        m_reset();
        #1;
        chk("async r2", r[2], 32'd0);
        chk("async r7", r[7], 32'd0);
        chk("async overflow", overflow, 32'd0);
        chk("async flag", {31'd0, flag}, 32'd0);
        chk("async jump", {31'd0, jump}, 32'd0);
        chk("async jumpTarget", jumpTarget, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        load(4'd3, 32'h55);
        chk("squash dropped r3", r[3], 32'h55);

        // Randomized run.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 12) begin
                ins = 32'd0;
                a = pick();
                b = pick();
            end else begin
                imb = ($urandom_range(0, 3) == 0);
                ra  = 4'($urandom_range(0, 15));
                rb  = 4'($urandom_range(0, 15));
                imm = 14'($urandom);
                opc = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(14, 31)) : 5'($urandom_range(0, 13));
                sel = $urandom_range(0, 16);
                rc  = (sel == 16) ? 4'd14 : 4'(sel);
                sel = $urandom_range(0, 9);
                if (sel < 6) cond = 3'd0;
                else if (sel == 6 || sel == 9) cond = 3'd1;
                else if (sel == 7) cond = 3'd2;
                else cond = 3'($urandom_range(3, 7));
                cbit = ($urandom_range(0, 4) == 0);
                ins = ins_w(imb, ra, rb, imm, opc, rc, cond, cbit);
                a = pick();
                if (imb) b = sext(imm);
                else if (rb >= 4'd14) b = 32'd0;
                else b = pick();
            end
            cyc(a, b, ins);
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: Execute

Interface
REQ-001 Parameters: none; the register count (14 GPRs r0..r13) and data width (32) SHALL be fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 Aval  input  32  A operand latched by Decode.
REQ-005 Bval  input  32  B operand latched by Decode; sign-extended Imm when Imb=1.
REQ-006 instructionExecute  input  32  instruction word; all-zero word is a bubble.
REQ-007 r  output  32 x [13:0]  architectural register file, driven straight from internal registers.
REQ-008 overflow  output  32  overflow/high-word register (architectural r15).
REQ-009 flag  output  1  condition flag written by compare instructions.
REQ-010 jump  output  1  one-cycle pulse; the fetch side SHALL redirect to jumpTarget.
REQ-011 jumpTarget  output  32  new PC; valid only while jump=1.

Function
REQ-012 Field split SHALL be Imb[31], Ra[30:27], Rb[26:23], Imm[26:13], Opc[12:8], Rc[7:4], Cond[3:1], Cmp[0].
REQ-013 Operand A SHALL be Aval when Ra=14, overflow when Ra=15, and r[Ra] from the internal file otherwise; this bypasses stale Decode reads of the previous cycle's write.
REQ-014 Operand B SHALL be Bval when Imb=1 or Rb>=14 (Bval is then 0), and r[Rb] otherwise.
REQ-015 Opc 0 SHALL be NOP: no register, overflow, flag or jump update.
REQ-016 Opcodes: 1 MOV(B), 2 AND, 3 OR, 4 XOR, 5 ADD, 6 ADDC(A+B+overflow[0]), 7 SUB(A-B), 8 MUL, 9 SHL(A<<B[4:0]), 10 SHR logical, 11 SRA, 12 EQ(A==B ?1:0), 13 LT signed(?1:0); Opc 14-31 SHALL behave as NOP.
REQ-017 ADD/ADDC SHALL set overflow to the 33rd sum bit zero-extended; SUB SHALL set overflow to 1 on borrow (A<B unsigned), else 0.
REQ-018 MUL SHALL be an unsigned 32x32 product completed in the same cycle: result = low word, overflow = high word.
REQ-019 Other opcodes SHALL leave overflow unchanged, except when Rc=15 (REQ-022).
REQ-020 Cond: 0 always, 1 execute if flag=1, 2 execute if flag=0, 3-7 never; a non-executed instruction SHALL change no state.
REQ-021 Cmp=1 SHALL set flag to (result != 0) and SHALL suppress the Rc write and jump; any overflow side effect still applies.
REQ-022 Cmp=0: Rc 0-13 writes r[Rc]; Rc=15 writes overflow (this write wins over the implicit overflow update); Rc=14 asserts jump for one cycle with jumpTarget = result.
REQ-023 After any cycle with jump=1, exactly the next non-bubble instruction arriving SHALL be squashed (treated as NOP); bubbles SHALL NOT consume the squash.
REQ-024 A jump instruction that is itself squashed SHALL NOT jump and SHALL NOT arm a new squash.
REQ-025 All register/flag updates SHALL take effect at the edge ending the execute cycle; latency is 1 cycle.
REQ-026 Shift amounts SHALL use B[4:0] only; all arithmetic SHALL wrap modulo 2^32.

Reset
REQ-027 On rst=1, asynchronously: r[0..13]=0, overflow=0, flag=0, jump=0, jumpTarget=0, squash pending cleared.
REQ-028 An instruction present while rst=1 SHALL have no effect; the first execution SHALL be on the first edge after rst deasserts.

Verification
REQ-029 ADD r1=0xFFFFFFFF, r2=1 into r3 -> r3=0, overflow=1; next-cycle ADDC Ra=15, Imm=0 into r4 -> r4=2.
REQ-030 MUL r1=0x10000, r2=0x10000 into r5 -> r5=0, overflow=1; back-to-back MOV r6<-r5 in the following cycle -> r6=0 (bypass path).
REQ-031 LT Cmp=1 of -1 vs 1 -> flag=1, Rc unchanged; then Cond=2 ADD -> no state change; then Cond=1 ADD -> executes.
REQ-032 MOV Imm=0x40 into Rc=14 -> jump=1 one cycle, jumpTarget=0x40; bubble, then ADD into r7 -> squashed, r7 unchanged; next instruction executes normally.
REQ-033 Assert rst mid-stream after several writes -> all outputs 0 immediately without a clock edge; pending squash discarded.
REQ-034 Opc=20 and Cond=5 instructions -> no change to any r, overflow, flag or jump.
